// File: rtl/spike_pkg.sv
// Shared constants and elaboration-time helpers for the sample framer family.
// Width helpers are constant functions so they can size ports and localparams.
package spike_pkg;

    localparam int BYTE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit tag field.
    function automatic int ch_width(input int num_channels);
        return (num_channels <= 1) ? 1 : clog2(num_channels);
    endfunction

    function automatic int entry_width(input int ch_w, input int data_width);
        return ch_w + data_width;
    endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Byte-side inputs and sample-side valid/ready outputs of the sample framer.
// slave is the framer's view; master is the view of the block driving it.
interface sample_framer_if
    import spike_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 4
);

    localparam int CH_W  = ch_width(NUM_CHANNELS);
    localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

    logic [BYTE_W-1:0]     byte_in;
    logic                  byte_valid;
    logic                  sync;
    logic [DATA_WIDTH-1:0] sample_out;
    logic [CH_W-1:0]       channel_out;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  frame_error;
    logic                  overflow;
    logic [LVL_W-1:0]      fill_level;

    // Handshake: a sample transfers on every rising clk edge where
    // sample_valid && sample_ready; sample_valid never waits on sample_ready,
    // and sample_out/channel_out hold steady until the transfer happens.
    // byte_valid has no back-pressure: a strobed byte is always taken.
    modport slave (
        input  byte_in, byte_valid, sync, sample_ready,
        output sample_out, channel_out, sample_valid, frame_error, overflow, fill_level
    );

    modport master (
        output byte_in, byte_valid, sync, sample_ready,
        input  sample_out, channel_out, sample_valid, frame_error, overflow, fill_level
    );

endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO with async reset and synchronous clear.
// A push into a full FIFO succeeds when a pop happens on the same edge.
module sample_fifo
    import spike_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks its contents at dout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/sample_framer.sv
// Assembles a strobed byte stream into channel-tagged samples with an
// inter-byte timeout for partial frames, buffered in an output FIFO.
module sample_framer
    import spike_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CHANNELS   = 2,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FIFO_DEPTH     = 4
) (
    input logic            clk,
    input logic            rst,
    sample_framer_if.slave bus
);

    localparam int BYTES = DATA_WIDTH / BYTE_W;
    localparam int CH_W  = ch_width(NUM_CHANNELS);
    localparam int IDX_W = (BYTES <= 1) ? 1 : clog2(BYTES);
    localparam int TO_W  = (TIMEOUT_CYCLES < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
    localparam int EW    = entry_width(CH_W, DATA_WIDTH);
    localparam int LVL_W = clog2(FIFO_DEPTH) + 1;
    // Single-byte samples can never be left partial, so the timeout is moot.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0) && (BYTES > 1);

    logic [IDX_W-1:0]      byte_idx;
    logic [CH_W-1:0]       chan;
    logic [TO_W-1:0]       tcnt;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_ins;
    logic                  frame_error_q;
    logic                  overflow_q;

    logic                  accept;
    logic                  last_byte;
    logic                  complete;
    logic                  idle_mid;
    logic                  expire;

    logic [EW-1:0]         fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [LVL_W-1:0]      fifo_level;

    assign accept    = bus.byte_valid && !bus.sync;
    assign last_byte = (int'(byte_idx) == BYTES - 1);
    assign complete  = accept && last_byte;
    assign idle_mid  = !bus.byte_valid && !bus.sync && (byte_idx != '0);
    assign expire    = TO_EN && idle_mid && (int'(tcnt) == TIMEOUT_CYCLES - 1);

    // Partial sample with the incoming byte dropped into its slot; on the
    // last byte this is the finished sample that goes into the FIFO.
    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (int'(byte_idx) == ((MSB_FIRST != 0) ? (BYTES - 1 - i) : i)) begin
                asm_ins[i*BYTE_W +: BYTE_W] = bus.byte_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            tcnt     <= '0;
            asm_q    <= '0;
        end else if (bus.sync) begin
            byte_idx <= '0;
            tcnt     <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            tcnt <= '0;
            if (last_byte) begin
                byte_idx <= '0;
                asm_q    <= '0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                asm_q    <= asm_ins;
            end
        end else if (expire) begin
            byte_idx <= '0;
            tcnt     <= '0;
            asm_q    <= '0;
        end else if (TO_EN && idle_mid) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // The channel advances on every completion, dropped or not, so the tag
    // stays aligned with the position of the sample in the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan <= '0;
        end else if (bus.sync) begin
            chan <= '0;
        end else if (complete) begin
            chan <= (int'(chan) == NUM_CHANNELS - 1) ? '0 : chan + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (bus.sync) begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_error_q <= expire;
            if (complete && fifo_full && !bus.sample_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.sync),
        .push  (complete),
        .pop   (bus.sample_ready),
        .din   ({chan, asm_ins}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign bus.sample_out   = fifo_dout[DATA_WIDTH-1:0];
    assign bus.channel_out  = fifo_dout[EW-1 -: CH_W];
    assign bus.sample_valid = !fifo_empty;
    assign bus.frame_error  = frame_error_q;
    assign bus.overflow     = overflow_q;
    assign bus.fill_level   = fifo_level;

endmodule

// File: tb/tb_sample_framer.sv
// Two framer configurations share one byte stream; a queue-based reference
// model predicts each one's FIFO and flags, and a monitor checks every cycle.
module tb_sample_framer;

    localparam int P_DW    [2] = '{16, 24};
    localparam int P_NCH   [2] = '{3, 2};
    localparam int P_MSB   [2] = '{1, 0};
    localparam int P_TO    [2] = '{4, 6};
    localparam int P_DEPTH [2] = '{4, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       sync = 1'b0;
    logic       sample_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_framer_if #(.DATA_WIDTH(16), .NUM_CHANNELS(3), .FIFO_DEPTH(4)) if0 ();
    sample_framer_if #(.DATA_WIDTH(24), .NUM_CHANNELS(2), .FIFO_DEPTH(4)) if1 ();

    assign if0.byte_in      = byte_in;
    assign if0.byte_valid   = byte_valid;
    assign if0.sync         = sync;
    assign if0.sample_ready = sample_ready;
    assign if1.byte_in      = byte_in;
    assign if1.byte_valid   = byte_valid;
    assign if1.sync         = sync;
    assign if1.sample_ready = sample_ready;

    sample_framer #(
        .DATA_WIDTH(16), .NUM_CHANNELS(3), .MSB_FIRST(1), .TIMEOUT_CYCLES(4), .FIFO_DEPTH(4)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sample_framer #(
        .DATA_WIDTH(24), .NUM_CHANNELS(2), .MSB_FIRST(0), .TIMEOUT_CYCLES(6), .FIFO_DEPTH(4)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_bytes [2][$];
    logic [23:0] exp_q   [2][$];
    int          exp_ch  [2][$];
    int          m_chan  [2];
    int          m_tcnt  [2];
    bit          m_ovf   [2];
    bit          m_ferr  [2];

    task automatic model_reset(input int d);
        m_bytes[d].delete();
        exp_q[d].delete();
        exp_ch[d].delete();
        m_chan[d] = 0;
        m_tcnt[d] = 0;
        m_ovf[d]  = 1'b0;
        m_ferr[d] = 1'b0;
    endtask

    task automatic model_step(input int d);
        logic [23:0] s;
        if (sync) begin
            model_reset(d);
            return;
        end
        m_ferr[d] = 1'b0;
        if (byte_valid) begin
            m_bytes[d].push_back(byte_in);
            m_tcnt[d] = 0;
            if (m_bytes[d].size() == P_DW[d] / 8) begin
                s = '0;
                for (int k = 0; k < m_bytes[d].size(); k++) begin
                    if (P_MSB[d] != 0) s = (s << 8) | 24'(m_bytes[d][k]);
                    else               s = s | (24'(m_bytes[d][k]) << (8 * k));
                end
                if (exp_q[d].size() < P_DEPTH[d]) begin
                    exp_q[d].push_back(s);
                    exp_ch[d].push_back(m_chan[d]);
                end else begin
                    m_ovf[d] = 1'b1;
                end
                m_chan[d] = (m_chan[d] + 1) % P_NCH[d];
                m_bytes[d].delete();
            end
        end else if (m_bytes[d].size() != 0 && P_TO[d] > 0) begin
            m_tcnt[d]++;
            if (m_tcnt[d] == P_TO[d]) begin
                m_bytes[d].delete();
                m_tcnt[d] = 0;
                m_ferr[d] = 1'b1;
            end
        end
    endtask

    // Runs after the monitor's pop for this cycle, so a full queue here
    // means the DUT had no pop to make room.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int d, input logic valid, input logic [23:0] s, input int ch,
                       input int fill, input logic ovf, input logic ferr);
        chk($sformatf("d%0d fill_level", d), fill, exp_q[d].size());
        chk($sformatf("d%0d overflow", d), 32'(ovf), 32'(m_ovf[d]));
        chk($sformatf("d%0d frame_error", d), 32'(ferr), 32'(m_ferr[d]));
        if (exp_q[d].size() != 0) begin
            chk($sformatf("d%0d sample_valid", d), 32'(valid), 32'd1);
            chk($sformatf("d%0d sample_out", d), 32'(s), 32'(exp_q[d][0]));
            chk($sformatf("d%0d channel_out", d), ch, exp_ch[d][0]);
            if (sample_ready) begin
                void'(exp_q[d].pop_front());
                void'(exp_ch[d].pop_front());
            end
        end else begin
            chk($sformatf("d%0d sample_valid", d), 32'(valid), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if0.sample_valid, 24'(if0.sample_out), int'(if0.channel_out),
                int'(if0.fill_level), if0.overflow, if0.frame_error);
            mon(1, if1.sample_valid, if1.sample_out, int'(if1.channel_out),
                int'(if1.fill_level), if1.overflow, if1.frame_error);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit bv, input logic [7:0] b, input bit sy, input bit rdy);
        byte_valid   = bv;
        byte_in      = b;
        sync         = sy;
        sample_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        drive(1'b1, b, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic do_sync();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        bit bv;
        bit rdy;

        #12;
        chk("reset sample_valid", 32'(if0.sample_valid), 32'd0);
        chk("reset sample_out", 32'(if0.sample_out), 32'd0);
        chk("reset channel_out", 32'(if0.channel_out), 32'd0);
        chk("reset frame_error", 32'(if0.frame_error), 32'd0);
        chk("reset overflow", 32'(if0.overflow), 32'd0);
        chk("reset fill_level", 32'(if0.fill_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 24-bit LSB-first assembly
        do_sync();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        chk("lsb24 valid", 32'(if1.sample_valid), 32'd1);
        chk("lsb24 sample", 32'(if1.sample_out), 32'h030201);
        chk("lsb24 channel", 32'(if1.channel_out), 32'd0);

        // 16-bit MSB-first, back to back with the consumer ready
        do_sync();
        send(8'hAB, 1'b1);
        send(8'hCD, 1'b1);
        chk("msb16 first valid", 32'(if0.sample_valid), 32'd1);
        chk("msb16 first sample", 32'(if0.sample_out), 32'hABCD);
        chk("msb16 first channel", 32'(if0.channel_out), 32'd0);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        chk("msb16 second sample", 32'(if0.sample_out), 32'h1234);
        chk("msb16 second channel", 32'(if0.channel_out), 32'd1);

        // inter-byte timeout
        do_sync();
        send(8'hAA, 1'b0);
        idle(3, 1'b0);
        chk("timeout early", 32'(if0.frame_error), 32'd0);
        idle(1, 1'b0);
        chk("timeout pulse", 32'(if0.frame_error), 32'd1);
        send(8'h11, 1'b0);
        chk("timeout single pulse", 32'(if0.frame_error), 32'd0);
        send(8'h22, 1'b0);
        chk("after timeout sample", 32'(if0.sample_out), 32'h1122);
        chk("after timeout channel", 32'(if0.channel_out), 32'd0);
        chk("after timeout overflow", 32'(if0.overflow), 32'd0);

        // overflow with a stalled consumer
        do_sync();
        for (int k = 0; k < 5; k++) begin
            send(8'h10 + 8'(k), 1'b0);
            send(8'h20 + 8'(k), 1'b0);
        end
        chk("full fill_level", 32'(if0.fill_level), 32'd4);
        chk("full overflow", 32'(if0.overflow), 32'd1);
        chk("full head sample", 32'(if0.sample_out), 32'h1020);
        chk("full head channel", 32'(if0.channel_out), 32'd0);

        // push and pop together while full
        send(8'h15, 1'b0);
        send(8'h25, 1'b1);
        chk("full push+pop fill_level", 32'(if0.fill_level), 32'd4);
        chk("full push+pop overflow", 32'(if0.overflow), 32'd1);
        chk("full push+pop head", 32'(if0.sample_out), 32'h1121);
        chk("full push+pop head channel", 32'(if0.channel_out), 32'd1);
        idle(6, 1'b1);
        chk("drained fill_level", 32'(if0.fill_level), 32'd0);

        // sync mid-sample beats a simultaneous byte
        do_sync();
        send(8'h40, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        chk("sync fill_level", 32'(if0.fill_level), 32'd0);
        chk("sync valid", 32'(if0.sample_valid), 32'd0);
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        chk("post sync sample", 32'(if0.sample_out), 32'h5A5B);
        chk("post sync channel", 32'(if0.channel_out), 32'd0);

        // asynchronous reset mid-sample, observed before the next edge
        send(8'h66, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(if0.sample_valid), 32'd0);
        chk("async rst sample", 32'(if0.sample_out), 32'd0);
        chk("async rst fill_level", 32'(if0.fill_level), 32'd0);
        chk("async rst overflow", 32'(if0.overflow), 32'd0);
        chk("async rst d1 fill_level", 32'(if1.fill_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // randomized traffic with bursty gaps and stalls
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (gap > 0) begin
                bv = 1'b0;
                gap--;
            end else begin
                bv = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 29) == 0) gap = $urandom_range(1, 8);
            end
            if (((i / 500) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
            else                      rdy = ($urandom_range(0, 3) == 0);
            drive(bv, 8'($urandom_range(0, 255)), ($urandom_range(0, 199) == 0), rdy);
        end
        idle(20, 1'b1);
        chk("final d0 fill_level", 32'(if0.fill_level), 32'd0);
        chk("final d1 fill_level", 32'(if1.fill_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
